pipe_idexe_fwd: RTL and testbench



---
 rtl/pipe_idexe_fwd.sv | 147 ++++++++++++++
 tb/tb_pipe_idexe_fwd.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_idexe_fwd.sv
// ID/EXE boundary: operand forwarding from EXE/MEM, load-use interlock with bubble
// injection, the ID/EXE pipeline register and a saturating interlock-cycle counter.
module pipe_idexe_fwd (
    input  logic        clock,
    input  logic        reset,
    input  logic        dwreg,
    input  logic        dm2reg,
    input  logic        dwmem,
    input  logic        djal,
    input  logic        daluimm,
    input  logic        dshift,
    input  logic [3:0]  daluc,
    input  logic [4:0]  drn,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        users,
    input  logic        usert,
    input  logic [31:0] qa,
    input  logic [31:0] qb,
    input  logic [31:0] dimm,
    input  logic [31:0] dpc4,
    input  logic [31:0] ealu,
    input  logic [4:0]  ern,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic [4:0]  mrn,
    input  logic [31:0] malu,
    input  logic [31:0] mmo,
    output logic        wpcir,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic        ejal,
    output logic        ealuimm,
    output logic        eshift,
    output logic [3:0]  ealuc,
    output logic [4:0]  ern0,
    output logic [31:0] ea,
    output logic [31:0] eb,
    output logic [31:0] eimm,
    output logic [31:0] epc4,
    output logic [31:0] stall_cnt
);

    logic        stall;
    logic        exe_hit_a, exe_hit_b;
    logic        mem_hit_a, mem_hit_b;
    logic [31:0] fwd_a_val, fwd_b_val;

    always_comb begin
        // A load in EXE cannot forward; it either stalls or is picked up from MEM next cycle.
        exe_hit_a = ewreg & (ern != 5'd0) & (ern == rs) & ~em2reg;
        exe_hit_b = ewreg & (ern != 5'd0) & (ern == rt) & ~em2reg;
        mem_hit_a = mwreg & (mrn != 5'd0) & (mrn == rs);
        mem_hit_b = mwreg & (mrn != 5'd0) & (mrn == rt);

        fwda = 2'd0;
        if (exe_hit_a) begin
            fwda = 2'd1;
        end else if (mem_hit_a) begin
            fwda = mm2reg ? 2'd3 : 2'd2;
        end

        fwdb = 2'd0;
        if (exe_hit_b) begin
            fwdb = 2'd1;
        end else if (mem_hit_b) begin
            fwdb = mm2reg ? 2'd3 : 2'd2;
        end
    end

    always_comb begin
        fwd_a_val = qa;
        unique case (fwda)
            2'd0: fwd_a_val = qa;
            2'd1: fwd_a_val = ealu;
            2'd2: fwd_a_val = malu;
            2'd3: fwd_a_val = mmo;
            default: fwd_a_val = qa;
        endcase

        fwd_b_val = qb;
        unique case (fwdb)
            2'd0: fwd_b_val = qb;
            2'd1: fwd_b_val = ealu;
            2'd2: fwd_b_val = malu;
            2'd3: fwd_b_val = mmo;
            default: fwd_b_val = qb;
        endcase
    end

    always_comb begin
        stall = ewreg & em2reg & (ern != 5'd0) &
                ((users & (ern == rs)) | (usert & (ern == rt)));
        wpcir = ~stall;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ewreg     <= 1'b0;
            em2reg    <= 1'b0;
            ewmem     <= 1'b0;
            ejal      <= 1'b0;
            ealuimm   <= 1'b0;
            eshift    <= 1'b0;
            ealuc     <= 4'd0;
            ern0      <= 5'd0;
            ea        <= 32'd0;
            eb        <= 32'd0;
            eimm      <= 32'd0;
            epc4      <= 32'd0;
            stall_cnt <= 32'd0;
        end else if (stall) begin
            ewreg     <= 1'b0;
            em2reg    <= 1'b0;
            ewmem     <= 1'b0;
            ejal      <= 1'b0;
            ealuimm   <= 1'b0;
            eshift    <= 1'b0;
            ealuc     <= 4'd0;
            ern0      <= 5'd0;
            ea        <= 32'd0;
            eb        <= 32'd0;
            eimm      <= 32'd0;
            epc4      <= 32'd0;
            if (stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end else begin
            ewreg     <= dwreg;
            em2reg    <= dm2reg;
            ewmem     <= dwmem;
            ejal      <= djal;
            ealuimm   <= daluimm;
            eshift    <= dshift;
            ealuc     <= daluc;
            ern0      <= drn;
            ea        <= fwd_a_val;
            eb        <= fwd_b_val;
            eimm      <= dimm;
            epc4      <= dpc4;
        end
    end

endmodule

// File: tb/tb_pipe_idexe_fwd.sv
// Scoreboard bench for pipe_idexe_fwd: a small reference model pushes the expected
// E-register image per cycle; each test pops it after the edge and compares.
module tb_pipe_idexe_fwd;

    logic        clock = 1'b0;
    logic        reset;
    logic        dwreg, dm2reg, dwmem, djal, daluimm, dshift;
    logic [3:0]  daluc;
    logic [4:0]  drn, rs, rt, ern, mrn;
    logic        users, usert, mwreg, mm2reg;
    logic [31:0] qa, qb, dimm, dpc4, ealu, malu, mmo;
    logic        wpcir;
    logic [1:0]  fwda, fwdb;
    logic        ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
    logic [3:0]  ealuc;
    logic [4:0]  ern0;
    logic [31:0] ea, eb, eimm, epc4, stall_cnt;

    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;
    logic [142:0] exp_q[$];
    logic [142:0] exp_e;
    logic         m_ewreg, m_em2reg, m_stall;
    logic [1:0]   m_fwda, m_fwdb;
    logic [31:0]  exp_cnt;

    pipe_idexe_fwd dut (
        .clock(clock), .reset(reset),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal),
        .daluimm(daluimm), .dshift(dshift), .daluc(daluc), .drn(drn),
        .rs(rs), .rt(rt), .users(users), .usert(usert), .qa(qa), .qb(qb),
        .dimm(dimm), .dpc4(dpc4), .ealu(ealu), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
        .wpcir(wpcir), .fwda(fwda), .fwdb(fwdb),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ejal(ejal),
        .ealuimm(ealuimm), .eshift(eshift), .ealuc(ealuc), .ern0(ern0),
        .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [142:0] e_image();
        return {ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern0, ea, eb, eimm, epc4};
    endfunction

    function automatic logic [33:0] model_fwd(input logic [4:0] r, input logic [31:0] q);
        if (m_ewreg && ern != 5'd0 && ern == r && !m_em2reg) return {2'd1, ealu};
        if (mwreg && mrn != 5'd0 && mrn == r) return mm2reg ? {2'd3, mmo} : {2'd2, malu};
        return {2'd0, q};
    endfunction

    // Predict the next E image from current inputs and the model's E state.
    task automatic push_model();
        logic [33:0] a, b;
        logic st;
        st = m_ewreg && m_em2reg && ern != 5'd0 &&
             ((users && ern == rs) || (usert && ern == rt));
        a = model_fwd(rs, qa);
        b = model_fwd(rt, qb);
        if (st) begin
            exp_q.push_back('0);
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
            m_ewreg = 1'b0;
            m_em2reg = 1'b0;
        end else begin
            exp_q.push_back({dwreg, dm2reg, dwmem, djal, daluimm, dshift, daluc, drn,
                             a[31:0], b[31:0], dimm, dpc4});
            m_ewreg = dwreg;
            m_em2reg = dm2reg;
        end
        m_stall = st;
        m_fwda = a[33:32];
        m_fwdb = b[33:32];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic wr, input logic m2r, input logic wm, input logic jal,
                          input logic aimm, input logic sh, input logic [3:0] aluc,
                          input logic [4:0] rn, input logic [31:0] imm, input logic [31:0] pc4);
        dwreg = wr; dm2reg = m2r; dwmem = wm; djal = jal; daluimm = aimm; dshift = sh;
        daluc = aluc; drn = rn; dimm = imm; dpc4 = pc4;
    endtask

    task automatic clear_inputs();
        set_id(0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 32'd0, 32'd0);
        rs = 0; rt = 0; users = 0; usert = 0; qa = 0; qb = 0;
        ealu = 0; ern = 0; mwreg = 0; mm2reg = 0; mrn = 0; malu = 0; mmo = 0;
    endtask

    // One clocked cycle whose E image is checked against the model.
    task automatic cycle_checked(input string name);
        push_model();
        tick();
        exp_e = exp_q.pop_front();
        n_checks++;
        if (e_image() !== exp_e) begin
            n_fail++;
            $display("FAIL %s e_regs: got %h expected %h", name, e_image(), exp_e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        m_ewreg = 0; m_em2reg = 0; exp_cnt = 0;
        #1;
        n_checks++;
        if (e_image() !== '0) begin n_fail++; $display("FAIL reset e_regs: got %h expected 0", e_image()); end
        n_checks++;
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset stall_cnt: got %h expected 0", stall_cnt); end
        tick();
        reset = 1'b0;
        set_id(1, 1, 0, 0, 0, 0, 4'd2, 5'd8, 32'h4, 32'h8);
        cycle_checked("reset_setup");
        ern = 5'd8; rs = 5'd8; users = 1'b1;
        #1;
        n_checks++;
        if (wpcir !== 1'b0) begin n_fail++; $display("FAIL reset_prestall wpcir: got %b expected 0", wpcir); end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (e_image() !== '0) begin n_fail++; $display("FAIL midstall_reset e_regs: got %h expected 0", e_image()); end
        n_checks++;
        if (wpcir !== 1'b1) begin n_fail++; $display("FAIL midstall_reset wpcir: got %b expected 1", wpcir); end
        n_checks++;
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL midstall_reset stall_cnt: got %h expected 0", stall_cnt); end
        tick();
        reset = 1'b0;
        clear_inputs();
        m_ewreg = 0; m_em2reg = 0; exp_cnt = 0;
    endtask

    task automatic test_exe_fwd();
        set_id(1, 0, 0, 0, 0, 0, 4'h3, 5'd10, 32'h10, 32'h104);
        cycle_checked("exe_setup");
        ern = 5'd5; ealu = 32'h1234;
        rs = 5'd5; users = 1; qa = 0; rt = 5'd9; usert = 1; qb = 32'h55;
        set_id(1, 0, 1, 0, 1, 1, 4'hA, 5'd11, 32'hFFFF_FFF0, 32'h108);
        #1;
        n_checks++;
        if (fwda !== 2'd1 || fwdb !== 2'd0 || wpcir !== 1'b1) begin
            n_fail++; $display("FAIL exe_fwd selects: got %0d/%0d/%b expected 1/0/1", fwda, fwdb, wpcir);
        end
        cycle_checked("exe_fwd");
        n_checks++;
        if (ea !== 32'h1234 || eb !== 32'h55) begin
            n_fail++; $display("FAIL exe_fwd operands: got %h/%h expected 00001234/00000055", ea, eb);
        end
    endtask

    task automatic test_priority();
        ern = 5'd7; ealu = 32'hAAAA;
        mwreg = 1; mrn = 5'd7; malu = 32'hBBBB; mm2reg = 0; mmo = 32'hCCCC;
        rs = 5'd7; rt = 5'd7; users = 1; usert = 1; qa = 32'h1; qb = 32'h2;
        set_id(1, 0, 0, 0, 0, 0, 4'h1, 5'd12, 32'h0, 32'h10C);
        #1;
        n_checks++;
        if (fwda !== 2'd1 || fwdb !== 2'd1) begin
            n_fail++; $display("FAIL priority selects: got %0d/%0d expected 1/1", fwda, fwdb);
        end
        cycle_checked("priority");
        n_checks++;
        if (eb !== 32'hAAAA || ea !== 32'hAAAA) begin
            n_fail++; $display("FAIL priority operands: got %h/%h expected 0000aaaa/0000aaaa", ea, eb);
        end
        ern = 5'd3;
        #1;
        n_checks++;
        if (fwdb !== 2'd2) begin n_fail++; $display("FAIL mem_alu fwdb: got %0d expected 2", fwdb); end
        cycle_checked("mem_alu");
        mm2reg = 1;
        #1;
        n_checks++;
        if (fwdb !== 2'd3) begin n_fail++; $display("FAIL mem_load fwdb: got %0d expected 3", fwdb); end
        cycle_checked("mem_load");
        n_checks++;
        if (eb !== 32'hCCCC) begin n_fail++; $display("FAIL mem_load eb: got %h expected 0000cccc", eb); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        set_id(1, 1, 0, 0, 0, 0, 4'h0, 5'd8, 32'h0, 32'h200);
        cycle_checked("lu_setup");
        ern = 5'd8; rs = 5'd8; users = 0; rt = 5'd4; usert = 1;
        #1;
        n_checks++;
        if (wpcir !== 1'b1) begin n_fail++; $display("FAIL lu_unused_rs wpcir: got %b expected 1", wpcir); end
        users = 1; qa = 32'h99;
        set_id(1, 0, 1, 0, 0, 0, 4'h2, 5'd9, 32'h0, 32'h204);
        #1;
        n_checks++;
        if (wpcir !== 1'b0) begin n_fail++; $display("FAIL lu_stall wpcir: got %b expected 0", wpcir); end
        cycle_checked("lu_bubble");
        n_checks++;
        if (ewreg !== 1'b0 || ewmem !== 1'b0 || stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL lu_bubble state: got %b/%b/%h expected 0/0/00000001", ewreg, ewmem, stall_cnt);
        end
        ern = 5'd0; mwreg = 1; mrn = 5'd8; mm2reg = 1; mmo = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (wpcir !== 1'b1 || fwda !== 2'd3) begin
            n_fail++; $display("FAIL lu_resume selects: got %b/%0d expected 1/3", wpcir, fwda);
        end
        cycle_checked("lu_resume");
        n_checks++;
        if (ea !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lu_resume ea: got %h expected deadbeef", ea); end
        clear_inputs();
    endtask

    task automatic test_reg0();
        set_id(1, 1, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h300);
        cycle_checked("r0_setup");
        ern = 0; rs = 0; rt = 0; users = 1; usert = 1; qa = 32'h77; qb = 32'h88;
        mwreg = 1; mrn = 0; malu = 32'h5; mm2reg = 0;
        #1;
        n_checks++;
        if (wpcir !== 1'b1 || fwda !== 2'd0 || fwdb !== 2'd0) begin
            n_fail++; $display("FAIL reg0 selects: got %b/%0d/%0d expected 1/0/0", wpcir, fwda, fwdb);
        end
        cycle_checked("reg0");
        n_checks++;
        if (ea !== 32'h77 || eb !== 32'h88) begin
            n_fail++; $display("FAIL reg0 operands: got %h/%h expected 00000077/00000088", ea, eb);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            set_id($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                   $urandom_range(1), $urandom_range(1), 4'($urandom), 5'($urandom),
                   $urandom, $urandom);
            rs = 5'($urandom_range(3)); rt = 5'($urandom_range(3));
            users = $urandom_range(1); usert = $urandom_range(1);
            qa = $urandom; qb = $urandom; ealu = $urandom; malu = $urandom; mmo = $urandom;
            ern = 5'($urandom_range(3)); mrn = 5'($urandom_range(3));
            mwreg = $urandom_range(1); mm2reg = $urandom_range(1);
            push_model();
            #1;
            n_checks++;
            if (wpcir !== !m_stall || fwda !== m_fwda || fwdb !== m_fwdb) begin
                n_fail++;
                $display("FAIL b2b[%0d] comb: got %b/%0d/%0d expected %b/%0d/%0d",
                         i, wpcir, fwda, fwdb, !m_stall, m_fwda, m_fwdb);
            end
            tick();
            exp_e = exp_q.pop_front();
            n_checks++;
            if (e_image() !== exp_e || stall_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL b2b[%0d] e_regs: got %h cnt %h expected %h cnt %h",
                         i, e_image(), stall_cnt, exp_e, exp_cnt);
            end
        end
        clear_inputs();
        cycle_checked("b2b_drain");
    endtask

    task automatic test_saturation();
        set_id(1, 1, 0, 0, 0, 0, 4'h0, 5'd6, 32'h0, 32'h400);
        cycle_checked("sat_setup1");
        force dut.stall_cnt = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        set_id(0, 0, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h0);
        ern = 5'd6; rs = 5'd6; users = 1;
        cycle_checked("sat_stall1");
        release dut.stall_cnt;
        #1;
        n_checks++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_first stall_cnt: got %h expected ffffffff", stall_cnt);
        end
        users = 0;
        set_id(1, 1, 0, 0, 0, 0, 4'h0, 5'd6, 32'h0, 32'h404);
        cycle_checked("sat_setup2");
        users = 1;
        set_id(0, 0, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h0);
        cycle_checked("sat_stall2");
        n_checks++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_hold stall_cnt: got %h expected ffffffff", stall_cnt);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_exe_fwd();
        test_priority();
        test_load_use();
        test_reg0();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
